// File: rtl/flow_step_ctrl.sv
// Run-control stage for the rotating LED chain: synchronizes and debounces three active-low
// keys, keeps speed/pause/direction state and emits a one-cycle step pulse from a prescaler.
module flow_step_ctrl #(
    parameter int unsigned CNT_W     = 26,
    parameter int unsigned DIV_BASE  = 12500000,
    parameter int unsigned DB_W      = 20,
    parameter int unsigned DB_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_speed,
    input  logic       key_pause,
    input  logic       key_dir,
    output logic       step,
    output logic       dir,
    output logic [1:0] speed,
    output logic       paused
);

    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV     = CNT_W'(DIV_BASE);

    // Key index: 0 = speed, 1 = pause, 2 = dir.
    logic [2:0]      keys;
    logic [2:0]      sync1_q, sync2_q;
    logic [2:0]      db_q, db_d;
    logic [2:0]      press_q, press_d;
    logic [DB_W-1:0] db_cnt_q [3];
    logic [DB_W-1:0] db_cnt_d [3];

    logic [CNT_W-1:0] pre_q, pre_d;
    logic [CNT_W-1:0] period_m1;
    logic             step_q, step_d;
    logic             dir_q, dir_d;
    logic [1:0]       speed_q, speed_d;
    logic             paused_q, paused_d;

    assign keys = {key_dir, key_pause, key_speed};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 3'b111;
            sync2_q <= 3'b111;
            db_q    <= 3'b111;
            press_q <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= keys;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            press_q <= press_d;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    // A level is accepted only after DB_CYCLES consecutive disagreeing cycles.
    always_comb begin
        db_d    = db_q;
        press_d = 3'b000;
        for (int i = 0; i < 3; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    db_d[i]    = sync2_q[i];
                    press_d[i] = ~sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign period_m1 = (DIV >> speed_q) - CNT_W'(1);

    // The prescaler looks at the current paused state, so a pause press landing on terminal
    // count still lets that step out; a speed press overrides everything.
    always_comb begin
        pre_d    = pre_q;
        step_d   = 1'b0;
        speed_d  = speed_q;
        paused_d = paused_q ^ press_q[1];
        dir_d    = dir_q ^ press_q[2];
        if (press_q[0]) begin
            pre_d   = '0;
            speed_d = speed_q + 2'd1;
        end else if (!paused_q) begin
            if (pre_q == period_m1) begin
                step_d = 1'b1;
                pre_d  = '0;
            end else begin
                pre_d = pre_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q    <= '0;
            step_q   <= 1'b0;
            dir_q    <= 1'b0;
            speed_q  <= 2'd0;
            paused_q <= 1'b0;
        end else begin
            pre_q    <= pre_d;
            step_q   <= step_d;
            dir_q    <= dir_d;
            speed_q  <= speed_d;
            paused_q <= paused_d;
        end
    end

    assign step   = step_q;
    assign dir    = dir_q;
    assign speed  = speed_q;
    assign paused = paused_q;

endmodule
